gpr_write_arbiter: RTL and testbench

Write-back arbiter in front of the general-purpose register file's single write port. It merges the single-cycle ALU result stream with results from the multi-cycle mul/div unit, and buffers mul/div results in a small FIFO. It drives the register file's write enable, write address and write data from registers, so at most one write is presented per cycle. A starvation counter forces a mul/div write through by stalling the ALU stream.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/gpr_write_arbiter.sv | 108 ++++++++++
 tb/tb_gpr_write_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared register-file constants and the write-back entry type.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One buffered register write: destination plus result.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Which source owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_FORCE = 2'd1,
        SEL_ALU   = 2'd2,
        SEL_DRAIN = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding pending mul/div register writes.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty; no pass-through.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wdata,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset: entries are only ever read while count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Merges the ALU result stream and buffered mul/div results onto the single register-file write port.
// Latency: ALU result at N is written out at N+1; mul/div result accepted at N is written out at N+2 at the earliest.
// Backpressure: mdReady = !full; aluStall stalls the ALU only when a starved FIFO head is forced through.
module gpr_write_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aluValid,
    input  logic [REG_ADDR_W-1:0] aluDest,
    input  logic [DATA_W-1:0]     aluData,
    output logic                  aluStall,
    input  logic                  mdValid,
    output logic                  mdReady,
    input  logic [REG_ADDR_W-1:0] mdDest,
    input  logic [DATA_W-1:0]     mdData,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] a3,
    output logic [DATA_W-1:0]     writeSrc,
    output logic                  mdPending
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    wb_sel_e        sel;
    wb_entry_t      head;
    wb_entry_t      push_entry;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           md_push;
    logic [SC_W-1:0] starve_cnt;

    // Results for r0 are accepted but never stored, so they can never reach the port.
    assign mdReady    = !fifo_full;
    assign md_push    = mdValid && mdReady && (mdDest != REG_ZERO);
    assign push_entry = '{dest: mdDest, data: mdData};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (md_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Slot owner for this cycle: a starved head beats the ALU, the ALU beats a normal drain.
    always_comb begin
        sel = SEL_IDLE;
        if (!fifo_empty && (starve_cnt == SC_W'(STARVE_LIMIT))) begin
            sel = SEL_FORCE;
        end else if (aluValid && (aluDest != REG_ZERO)) begin
            sel = SEL_ALU;
        end else if (!fifo_empty) begin
            sel = SEL_DRAIN;
        end
    end

    assign aluStall = (sel == SEL_FORCE);
    assign fifo_pop = (sel == SEL_FORCE) || (sel == SEL_DRAIN);

    // Register the winning write; address and data hold when the port goes idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regWrite <= 1'b0;
            a3       <= REG_ZERO;
            writeSrc <= '0;
        end else begin
            regWrite <= (sel != SEL_IDLE);
            if (sel == SEL_ALU) begin
                a3       <= aluDest;
                writeSrc <= aluData;
            end else if (fifo_pop) begin
                a3       <= head.dest;
                writeSrc <= head.data;
            end
        end
    end

    // Count cycles the head has waited; saturates so the forced drain condition stays asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Pending covers both queued entries and a mul/div write sitting in the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdPending <= 1'b0;
        end else begin
            mdPending <= md_push || !fifo_empty;
        end
    end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Self-checking bench for gpr_write_arbiter: directed vector table, hand sequences, randomized run against a queue model.
// Latency: checks outputs at the falling edge of each cycle.
// Backpressure: upstream sources hold their offers while aluStall / !mdReady.
module tb_gpr_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluValid;
    logic [4:0]  aluDest;
    logic [31:0] aluData;
    logic        aluStall;
    logic        mdValid;
    logic        mdReady;
    logic [4:0]  mdDest;
    logic [31:0] mdData;
    logic        regWrite;
    logic [4:0]  a3;
    logic [31:0] writeSrc;
    logic        mdPending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpr_write_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aluValid  (aluValid),
        .aluDest   (aluDest),
        .aluData   (aluData),
        .aluStall  (aluStall),
        .mdValid   (mdValid),
        .mdReady   (mdReady),
        .mdDest    (mdDest),
        .mdData    (mdData),
        .regWrite  (regWrite),
        .a3        (a3),
        .writeSrc  (writeSrc),
        .mdPending (mdPending)
    );

    typedef struct packed {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    typedef struct {
        logic        av;
        logic [4:0]  ad;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  md;
        logic [31:0] mdat;
        logic        e_stall;
        logic        e_rdy;
        logic        e_rw;
        logic [4:0]  e_a3;
        logic [31:0] e_ws;
        logic        e_pend;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                         input logic mv, input logic [4:0] md, input logic [31:0] mdat);
        aluValid = av;
        aluDest  = ad;
        aluData  = adat;
        mdValid  = mv;
        mdDest   = md;
        mdData   = mdat;
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                                input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                                input logic st, input logic rd, input logic rw,
                                input logic [4:0] ea3, input logic [31:0] ews, input logic pd);
        vec_t v;
        v.av = av; v.ad = ad; v.adat = adat;
        v.mv = mv; v.md = md; v.mdat = mdat;
        v.e_stall = st; v.e_rdy = rd; v.e_rw = rw;
        v.e_a3 = ea3; v.e_ws = ews; v.e_pend = pd;
        return v;
    endfunction

    // Reference model state
    ent_t        q[$];
    int          m_starve;
    logic        m_rw;
    logic [4:0]  m_a3;
    logic [31:0] m_ws;
    logic        m_pend;

    initial begin
        vec_t        tbl[20];
        logic [4:0]  fd[3];
        logic [31:0] fdat[3];
        ent_t        seen[$];
        int          nxt;
        int          third_acc;
        logic        a_hold;
        logic        any_wr;
        logic        prev_stall;
        logic        prev_rdy;

        // Cycle-by-cycle directed vectors starting right after reset release.
        //            av ad  adat      mv md  mdat        stall rdy rw a3  ws          pend
        tbl[0]  = mk(1, 3,  32'h11,   0, 0,  32'h0,      0, 1, 0, 0,  32'h0,      0);
        tbl[1]  = mk(0, 0,  32'h0,    1, 7,  32'hDEAD,   0, 1, 1, 3,  32'h11,     0);
        tbl[2]  = mk(0, 0,  32'h0,    0, 0,  32'h0,      0, 1, 0, 3,  32'h11,     1);
        tbl[3]  = mk(0, 0,  32'h0,    0, 0,  32'h0,      0, 1, 1, 7,  32'hDEAD,   1);
        tbl[4]  = mk(0, 0,  32'h0,    0, 0,  32'h0,      0, 1, 0, 7,  32'hDEAD,   0);
        tbl[5]  = mk(0, 0,  32'h0,    1, 5,  32'hA5,     0, 1, 0, 7,  32'hDEAD,   0);
        tbl[6]  = mk(1, 9,  32'h96,   0, 0,  32'h0,      0, 1, 0, 7,  32'hDEAD,   1);
        tbl[7]  = mk(1, 9,  32'h97,   0, 0,  32'h0,      0, 1, 1, 9,  32'h96,     1);
        tbl[8]  = mk(1, 9,  32'h98,   0, 0,  32'h0,      0, 1, 1, 9,  32'h97,     1);
        tbl[9]  = mk(1, 9,  32'h99,   0, 0,  32'h0,      0, 1, 1, 9,  32'h98,     1);
        tbl[10] = mk(1, 9,  32'h9A,   0, 0,  32'h0,      1, 1, 1, 9,  32'h99,     1);
        tbl[11] = mk(1, 9,  32'h9A,   0, 0,  32'h0,      0, 1, 1, 5,  32'hA5,     1);
        tbl[12] = mk(0, 0,  32'h0,    0, 0,  32'h0,      0, 1, 1, 9,  32'h9A,     0);
        tbl[13] = mk(0, 0,  32'h0,    0, 0,  32'h0,      0, 1, 0, 9,  32'h9A,     0);
        tbl[14] = mk(0, 0,  32'h0,    1, 0,  32'h55,     0, 1, 0, 9,  32'h9A,     0);
        tbl[15] = mk(0, 0,  32'h0,    0, 0,  32'h0,      0, 1, 0, 9,  32'h9A,     0);
        tbl[16] = mk(0, 0,  32'h0,    1, 12, 32'hCC,     0, 1, 0, 9,  32'h9A,     0);
        tbl[17] = mk(1, 0,  32'h77,   0, 0,  32'h0,      0, 1, 0, 9,  32'h9A,     1);
        tbl[18] = mk(0, 0,  32'h0,    0, 0,  32'h0,      0, 1, 1, 12, 32'hCC,     1);
        tbl[19] = mk(0, 0,  32'h0,    0, 0,  32'h0,      0, 1, 0, 12, 32'hCC,     0);

        // Reset held with random inputs
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
            @(negedge clk);
            check("rst_regWrite", regWrite, 0);
            check("rst_a3", a3, 0);
            check("rst_writeSrc", writeSrc, 0);
            check("rst_mdReady", mdReady, 1);
            check("rst_mdPending", mdPending, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].av, tbl[i].ad, tbl[i].adat, tbl[i].mv, tbl[i].md, tbl[i].mdat);
            @(negedge clk);
            check($sformatf("tbl%0d_aluStall", i), aluStall, tbl[i].e_stall);
            check($sformatf("tbl%0d_mdReady", i), mdReady, tbl[i].e_rdy);
            check($sformatf("tbl%0d_regWrite", i), regWrite, tbl[i].e_rw);
            check($sformatf("tbl%0d_a3", i), a3, tbl[i].e_a3);
            check($sformatf("tbl%0d_writeSrc", i), writeSrc, tbl[i].e_ws);
            check($sformatf("tbl%0d_mdPending", i), mdPending, tbl[i].e_pend);
            @(posedge clk);
            #1;
        end

        // Full FIFO backpressure: three offers while ALU is busy
        fd[0] = 5'd2; fd[1] = 5'd3; fd[2] = 5'd4;
        fdat[0] = 32'h202; fdat[1] = 32'h303; fdat[2] = 32'h404;
        nxt = 0;
        third_acc = -1;
        a_hold = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (!a_hold) begin
                aluValid = (cyc < 7);
                aluDest  = 5'd1;
                aluData  = 32'h100 + 32'(cyc);
            end
            mdValid = (nxt < 3);
            mdDest  = (nxt < 3) ? fd[nxt] : 5'd0;
            mdData  = (nxt < 3) ? fdat[nxt] : 32'h0;
            @(negedge clk);
            if (cyc == 2) check("full_mdReady_low", mdReady, 0);
            if (cyc == 5) begin
                check("full_stall_forced", aluStall, 1);
                check("full_ready_low_on_pop", mdReady, 0);
            end
            if (regWrite && a3 >= 5'd2 && a3 <= 5'd4) seen.push_back('{d: a3, v: writeSrc});
            if (mdValid && mdReady) begin
                if (nxt == 2) third_acc = cyc;
                nxt++;
            end
            a_hold = aluValid && aluStall;
            @(posedge clk);
            #1;
        end
        check("full_third_accept_cycle", 32'(third_acc), 32'd6);
        check("full_md_write_count", 32'(seen.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < seen.size()) begin
                check($sformatf("full_order%0d_dest", i), seen[i].d, fd[i]);
                check($sformatf("full_order%0d_data", i), seen[i].v, fdat[i]);
            end
        end

        // Asynchronous reset with two entries queued
        drive(1, 1, 32'h1, 1, 20, 32'h2020);
        @(posedge clk); #1;
        drive(1, 1, 32'h2, 1, 21, 32'h2121);
        @(posedge clk); #1;
        drive(1, 1, 32'h3, 0, 0, 32'h0);
        check("ar_pre_regWrite", regWrite, 1);
        check("ar_pre_full", mdReady, 0);
        check("ar_pre_pending", mdPending, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_regWrite_async", regWrite, 0);
        check("ar_a3_async", a3, 0);
        check("ar_writeSrc_async", writeSrc, 0);
        check("ar_mdPending_async", mdPending, 0);
        check("ar_mdReady_async", mdReady, 1);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        any_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (regWrite || mdPending) any_wr = 1'b1;
            @(posedge clk); #1;
        end
        check("ar_entries_lost", any_wr, 0);

        // Randomized run against the queue model
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        m_starve = 0;
        m_rw = 1'b0; m_a3 = 5'd0; m_ws = 32'd0; m_pend = 1'b0;
        prev_stall = 1'b0;
        prev_rdy = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic m_stall;
            logic m_rdy;
            logic popped;
            logic md_out;
            int   sz;
            if (!(aluValid && prev_stall)) begin
                aluValid = ($urandom_range(0, 9) < 7);
                aluDest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                aluData  = $urandom;
            end
            if (!(mdValid && !prev_rdy)) begin
                mdValid = ($urandom_range(0, 9) < 4);
                mdDest  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mdData  = $urandom;
            end
            @(negedge clk);
            sz = q.size();
            m_stall = (sz > 0) && (m_starve == LIMIT);
            m_rdy = (sz < DEPTH);
            check("rnd_aluStall", aluStall, m_stall);
            check("rnd_mdReady", mdReady, m_rdy);
            check("rnd_regWrite", regWrite, m_rw);
            check("rnd_a3", a3, m_a3);
            check("rnd_writeSrc", writeSrc, m_ws);
            check("rnd_mdPending", mdPending, m_pend);
            popped = 1'b0;
            md_out = 1'b0;
            if (m_stall || (!(aluValid && aluDest != 5'd0) && sz > 0)) begin
                m_rw = 1'b1;
                m_a3 = q[0].d;
                m_ws = q[0].v;
                void'(q.pop_front());
                popped = 1'b1;
                md_out = 1'b1;
            end else if (aluValid && aluDest != 5'd0) begin
                m_rw = 1'b1;
                m_a3 = aluDest;
                m_ws = aluData;
            end else begin
                m_rw = 1'b0;
            end
            if (popped || sz == 0) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (mdValid && m_rdy && mdDest != 5'd0) q.push_back('{d: mdDest, v: mdData});
            m_pend = (q.size() > 0) || md_out;
            prev_stall = m_stall;
            prev_rdy = m_rdy;
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
